// File: rtl/fifo_cam_queue_if.sv
// Bus bundle for fifo_cam_queue: push/pop/flush handshake, probe input and status/hit outputs.
// slave = the queue itself, master = the store path / bench driving it.
interface fifo_cam_queue_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
);
  logic             PUSHI;
  logic [WIDTH-1:0] DATAI;
  logic             POPI;
  logic             FLUSHI;
  logic [WIDTH-1:0] CMPI;
  logic [WIDTH-1:0] DATAO;
  logic             VALIDO;
  logic             FULLO;
  logic             EMPTYO;
  logic [CNTW-1:0]  COUNTO;
  logic [DEPTH-1:0] CTLHITO;
  logic             ANYHITO;
  logic             ERRO;

  modport slave (
    input  PUSHI, DATAI, POPI, FLUSHI, CMPI,
    output DATAO, VALIDO, FULLO, EMPTYO, COUNTO, CTLHITO, ANYHITO, ERRO
  );

  modport master (
    output PUSHI, DATAI, POPI, FLUSHI, CMPI,
    input  DATAO, VALIDO, FULLO, EMPTYO, COUNTO, CTLHITO, ANYHITO, ERRO
  );
endinterface

// File: rtl/fifo_cam_queue.sv
// Shift-toward-head FIFO with internal valid tracking and masked broadside compare.
// Optional sticky overflow/underflow flag on ERRO is built when FIFO_CAM_ERR_CHK_EN is defined.
module fifo_cam_queue #(
  parameter int               DEPTH = 4,
  parameter int               WIDTH = 32,
  parameter int               CNTW  = 3,
  parameter logic [WIDTH-1:0] MASK  = {{(WIDTH-2){1'b0}}, 2'b11}
) (
  input logic              CLOCKI,
  input logic              RESET_D1_R_N,
  fifo_cam_queue_if.slave  bus
);

  if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
    $error("fifo_cam_queue: DEPTH must be 2..16");
  end
  if ((1 << CNTW) <= DEPTH) begin : g_bad_cntw
    $error("fifo_cam_queue: CNTW too narrow for DEPTH");
  end

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_n [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_n;
  logic [CNTW-1:0]  count_q, count_n;
  logic [CNTW-1:0]  wr_idx;
  logic             full, empty, pop_ok, push_ok;

  // Handshake: a pop only retires a valid head; a push is accepted when
  // there is room or when the same-cycle pop frees the top slot.
  always_comb begin
    full    = valid_q[DEPTH-1];
    empty   = ~valid_q[0];
    pop_ok  = bus.POPI & valid_q[0];
    push_ok = bus.PUSHI & (~full | pop_ok);
    wr_idx  = pop_ok ? (count_q - CNTW'(1)) : count_q;
  end

  always_comb begin
    data_n  = data_q;
    valid_n = valid_q;
    count_n = count_q;
    if (bus.FLUSHI) begin
      // Flush drops valids only; stale data stays but can never hit.
      valid_n = '0;
      count_n = '0;
    end else begin
      if (pop_ok) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          data_n[i] = data_q[i+1];
        end
        valid_n = valid_q >> 1;
      end
      if (push_ok) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNTW'(i) == wr_idx) begin
            data_n[i]  = bus.DATAI;
            valid_n[i] = 1'b1;
          end
        end
      end
      if (push_ok && !pop_ok) begin
        count_n = count_q + CNTW'(1);
      end else if (pop_ok && !push_ok) begin
        count_n = count_q - CNTW'(1);
      end
    end
  end

  always_ff @(posedge CLOCKI) begin
    if (!RESET_D1_R_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_n[i];
      end
      valid_q <= valid_n;
      count_q <= count_n;
    end
  end

  assign bus.DATAO  = data_q[0];
  assign bus.VALIDO = valid_q[0];
  assign bus.FULLO  = full;
  assign bus.EMPTYO = empty;
  assign bus.COUNTO = count_q;

  // Broadside compare sees stored state only; this cycle's push is not visible.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign bus.CTLHITO[g] = valid_q[g] & (&((data_q[g] ~^ bus.CMPI) | MASK));
  end
  assign bus.ANYHITO = |bus.CTLHITO;

`ifdef FIFO_CAM_ERR_CHK_EN
  logic err_q, overflow, underflow;
  assign overflow  = bus.PUSHI & full & ~pop_ok & ~bus.FLUSHI;
  assign underflow = bus.POPI & empty;

  always_ff @(posedge CLOCKI) begin
    if (!RESET_D1_R_N) begin
      err_q <= 1'b0;
    end else if ((overflow | underflow) && !err_q) begin
      err_q <= 1'b1;
`ifndef SYNTHESIS
      $display("fifo_cam_queue: protocol error (overflow=%0b underflow=%0b)", overflow, underflow);
`endif
    end
  end
  assign bus.ERRO = err_q;
`else
  assign bus.ERRO = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_cam_queue.sv
// Self-checking bench for fifo_cam_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_fifo_cam_queue;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int CNTW  = 3;
  localparam logic [WIDTH-1:0] MASK_C = 32'h0000_0003;

  logic CLOCKI = 1'b0;
  logic RESET_D1_R_N = 1'b0;

  fifo_cam_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) bus ();

  fifo_cam_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNTW(CNTW), .MASK(MASK_C)) dut (
    .CLOCKI       (CLOCKI),
    .RESET_D1_R_N (RESET_D1_R_N),
    .bus          (bus.slave)
  );

  // clock / watchdog
  always #5 CLOCKI = ~CLOCKI;
  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic err_m = 1'b0;

  function automatic logic [DEPTH-1:0] exp_hits(input logic [WIDTH-1:0] cmp);
    logic [DEPTH-1:0] h = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (((exp_q[i] ^ cmp) & ~MASK_C) == '0) h[i] = 1'b1;
    end
    return h;
  endfunction

  // driver: apply one cycle of stimulus, advance the model, settle after the edge
  task automatic drive(input bit push, input bit pop, input bit flush, input logic [WIDTH-1:0] din);
    bit pop_ok, push_ok;
    bus.PUSHI  = push;
    bus.POPI   = pop;
    bus.FLUSHI = flush;
    bus.DATAI  = din;
    if (!RESET_D1_R_N) begin
      exp_q.delete();
      err_m = 1'b0;
    end else begin
`ifdef FIFO_CAM_ERR_CHK_EN
      if ((push && exp_q.size() == DEPTH && !pop && !flush) || (pop && exp_q.size() == 0)) err_m = 1'b1;
`endif
      if (flush) begin
        exp_q.delete();
      end else begin
        pop_ok  = pop && exp_q.size() > 0;
        push_ok = push && (exp_q.size() < DEPTH || pop_ok);
        if (pop_ok) void'(exp_q.pop_front());
        if (push_ok) exp_q.push_back(din);
      end
    end
    @(posedge CLOCKI);
    #1;
    bus.PUSHI  = 1'b0;
    bus.POPI   = 1'b0;
    bus.FLUSHI = 1'b0;
  endtask

  task automatic test_reset();
    RESET_D1_R_N = 1'b0;
    drive(1'b1, 1'b0, 1'b0, $urandom());
    drive(1'b1, 1'b1, 1'b0, $urandom());
    RESET_D1_R_N = 1'b1;
    bus.CMPI = 32'h0;
    #1;
    total++; if (bus.COUNTO !== 3'd0) begin bad++; $display("FAIL reset_count: actual=%0d required=0", bus.COUNTO); end
    total++; if (bus.EMPTYO !== 1'b1) begin bad++; $display("FAIL reset_empty: actual=%b required=1", bus.EMPTYO); end
    total++; if (bus.FULLO !== 1'b0) begin bad++; $display("FAIL reset_full: actual=%b required=0", bus.FULLO); end
    total++; if (bus.VALIDO !== 1'b0) begin bad++; $display("FAIL reset_valid: actual=%b required=0", bus.VALIDO); end
    total++; if (bus.DATAO !== 32'h0) begin bad++; $display("FAIL reset_data: actual=%h required=0", bus.DATAO); end
    total++; if (bus.CTLHITO !== 4'b0 || bus.ANYHITO !== 1'b0) begin bad++; $display("FAIL reset_hit: actual=%b/%b required=0000/0", bus.CTLHITO, bus.ANYHITO); end
    total++; if (bus.ERRO !== 1'b0) begin bad++; $display("FAIL reset_err: actual=%b required=0", bus.ERRO); end
  endtask

  task automatic test_fill();
    drive(1'b1, 1'b0, 1'b0, 32'h11);
    drive(1'b1, 1'b0, 1'b0, 32'h22);
    drive(1'b1, 1'b0, 1'b0, 32'h33);
    drive(1'b1, 1'b0, 1'b0, 32'h44);
    total++; if (bus.COUNTO !== 3'd4) begin bad++; $display("FAIL fill_count: actual=%0d required=4", bus.COUNTO); end
    total++; if (bus.FULLO !== 1'b1) begin bad++; $display("FAIL fill_full: actual=%b required=1", bus.FULLO); end
    total++; if (bus.DATAO !== 32'h11) begin bad++; $display("FAIL fill_data: actual=%h required=11", bus.DATAO); end
    total++; if (bus.EMPTYO !== 1'b0) begin bad++; $display("FAIL fill_empty: actual=%b required=0", bus.EMPTYO); end
  endtask

  task automatic test_overflow();
    drive(1'b1, 1'b0, 1'b0, 32'h55);
    total++; if (bus.COUNTO !== 3'd4) begin bad++; $display("FAIL ovf_count: actual=%0d required=4", bus.COUNTO); end
    total++; if (bus.DATAO !== 32'h11) begin bad++; $display("FAIL ovf_data: actual=%h required=11", bus.DATAO); end
    total++; if (bus.ERRO !== err_m) begin bad++; $display("FAIL ovf_err: actual=%b required=%b", bus.ERRO, err_m); end
  endtask

  task automatic test_push_pop_full();
    drive(1'b1, 1'b1, 1'b0, 32'h55);
    bus.CMPI = 32'h55;
    #1;
    total++; if (bus.DATAO !== 32'h22) begin bad++; $display("FAIL pp_full_data: actual=%h required=22", bus.DATAO); end
    total++; if (bus.COUNTO !== 3'd4) begin bad++; $display("FAIL pp_full_count: actual=%0d required=4", bus.COUNTO); end
    total++; if (bus.FULLO !== 1'b1) begin bad++; $display("FAIL pp_full_full: actual=%b required=1", bus.FULLO); end
    total++; if (bus.CTLHITO !== 4'b1000) begin bad++; $display("FAIL pp_full_tail: actual=%b required=1000", bus.CTLHITO); end
  endtask

  task automatic test_compare();
    RESET_D1_R_N = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    RESET_D1_R_N = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h1000);
    drive(1'b1, 1'b0, 1'b0, 32'h2004);
    drive(1'b1, 1'b0, 1'b0, 32'h1002);
    bus.CMPI = 32'h1003;
    #1;
    total++; if (bus.CTLHITO !== 4'b0101) begin bad++; $display("FAIL cmp_hits: actual=%b required=0101", bus.CTLHITO); end
    total++; if (bus.ANYHITO !== 1'b1) begin bad++; $display("FAIL cmp_any: actual=%b required=1", bus.ANYHITO); end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    total++; if (bus.CTLHITO !== 4'b0010) begin bad++; $display("FAIL cmp_after_pop: actual=%b required=0010", bus.CTLHITO); end
  endtask

  task automatic test_empty_push_pop();
    RESET_D1_R_N = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    RESET_D1_R_N = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'hAA);
    total++; if (bus.COUNTO !== 3'd1) begin bad++; $display("FAIL epp_count: actual=%0d required=1", bus.COUNTO); end
    total++; if (bus.DATAO !== 32'hAA) begin bad++; $display("FAIL epp_data: actual=%h required=aa", bus.DATAO); end
    total++; if (bus.ERRO !== 1'b0) begin bad++; $display("FAIL epp_err: actual=%b required=0", bus.ERRO); end
  endtask

  task automatic test_flush();
    logic [WIDTH-1:0] c;
    drive(1'b1, 1'b0, 1'b0, 32'hB0);
    drive(1'b1, 1'b0, 1'b0, 32'hC0);
    drive(1'b1, 1'b1, 1'b1, 32'hD0);
    total++; if (bus.EMPTYO !== 1'b1) begin bad++; $display("FAIL flush_empty: actual=%b required=1", bus.EMPTYO); end
    total++; if (bus.COUNTO !== 3'd0) begin bad++; $display("FAIL flush_count: actual=%0d required=0", bus.COUNTO); end
    for (int k = 0; k < 4; k++) begin
      c = (k == 0) ? 32'hAA : (k == 1) ? 32'hB0 : (k == 2) ? 32'hD0 : $urandom();
      bus.CMPI = c;
      #1;
      total++; if (bus.CTLHITO !== 4'b0) begin bad++; $display("FAIL flush_hit: cmp=%h actual=%b required=0000", c, bus.CTLHITO); end
    end
    drive(1'b1, 1'b0, 1'b0, 32'h1234);
    drive(1'b1, 1'b0, 1'b0, 32'h5678);
    RESET_D1_R_N = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h9ABC);
    RESET_D1_R_N = 1'b1;
    bus.CMPI = 32'h0;
    #1;
    total++; if (bus.COUNTO !== 3'd0 || bus.EMPTYO !== 1'b1 || bus.FULLO !== 1'b0) begin bad++; $display("FAIL midreset_flags: actual=%0d/%b/%b required=0/1/0", bus.COUNTO, bus.EMPTYO, bus.FULLO); end
    total++; if (bus.VALIDO !== 1'b0 || bus.DATAO !== 32'h0) begin bad++; $display("FAIL midreset_head: actual=%b/%h required=0/0", bus.VALIDO, bus.DATAO); end
    total++; if (bus.CTLHITO !== 4'b0 || bus.ANYHITO !== 1'b0 || bus.ERRO !== 1'b0) begin bad++; $display("FAIL midreset_hit_err: actual=%b/%b/%b required=0000/0/0", bus.CTLHITO, bus.ANYHITO, bus.ERRO); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] c;
    logic [DEPTH-1:0] eh;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45, $urandom_range(0, 29) == 0,
            {$urandom_range(0, 7), 28'h0} | 32'($urandom_range(0, 15)));
      if (exp_q.size() > 0 && $urandom_range(0, 1) == 1)
        c = exp_q[$urandom_range(0, exp_q.size() - 1)] ^ 32'($urandom_range(0, 3));
      else
        c = {$urandom_range(0, 7), 28'h0} | 32'($urandom_range(0, 15));
      bus.CMPI = c;
      #1;
      eh = exp_hits(c);
      total++; if (bus.COUNTO !== CNTW'(exp_q.size())) begin bad++; $display("FAIL rnd_count[%0d]: actual=%0d required=%0d", n, bus.COUNTO, exp_q.size()); end
      total++; if (bus.EMPTYO !== (exp_q.size() == 0)) begin bad++; $display("FAIL rnd_empty[%0d]: actual=%b required=%b", n, bus.EMPTYO, exp_q.size() == 0); end
      total++; if (bus.FULLO !== (exp_q.size() == DEPTH)) begin bad++; $display("FAIL rnd_full[%0d]: actual=%b required=%b", n, bus.FULLO, exp_q.size() == DEPTH); end
      total++; if (bus.VALIDO !== (exp_q.size() != 0)) begin bad++; $display("FAIL rnd_valid[%0d]: actual=%b required=%b", n, bus.VALIDO, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        total++; if (bus.DATAO !== exp_q[0]) begin bad++; $display("FAIL rnd_data[%0d]: actual=%h required=%h", n, bus.DATAO, exp_q[0]); end
      end
      total++; if (bus.CTLHITO !== eh) begin bad++; $display("FAIL rnd_hits[%0d]: cmp=%h actual=%b required=%b", n, c, bus.CTLHITO, eh); end
      total++; if (bus.ANYHITO !== (|eh)) begin bad++; $display("FAIL rnd_any[%0d]: actual=%b required=%b", n, bus.ANYHITO, |eh); end
      total++; if (bus.ERRO !== err_m) begin bad++; $display("FAIL rnd_err[%0d]: actual=%b required=%b", n, bus.ERRO, err_m); end
    end
  endtask

  initial begin
    bus.PUSHI  = 1'b0;
    bus.POPI   = 1'b0;
    bus.FLUSHI = 1'b0;
    bus.DATAI  = '0;
    bus.CMPI   = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_push_pop_full();
    test_compare();
    test_empty_push_pop();
    test_flush();
    test_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
